// File: rtl/lsu_pkg.sv
// Shared definitions for the memory-stage load/store controller.
// Holds the funct3 encodings, the response error codes and the FSM state type.
package lsu_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_ILLEGAL  = 2'b10,
        ERR_TIMEOUT  = 2'b11
    } rsp_err_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10,
        RESP = 2'b11
    } lsu_state_e;

endpackage

// File: rtl/lsu_strobe_gen.sv
// Combinational decode of an access: byte strobe, lane-replicated store data
// and the illegal/misaligned classification.
module lsu_strobe_gen
    import lsu_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [3:0]  strobe,
    output logic [31:0] wdata_rep,
    output rsp_err_e    err
);

    logic illegal;
    logic misaligned;

    always_comb begin
        strobe    = 4'b0000;
        wdata_rep = wdata;
        case (funct3[1:0])
            2'b00: begin
                strobe    = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
            end
            2'b01: begin
                strobe    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
            end
            2'b10: begin
                strobe    = 4'b1111;
                wdata_rep = wdata;
            end
            default: begin
                strobe    = 4'b0000;
                wdata_rep = wdata;
            end
        endcase
    end

    // Stores have no unsigned variants, so any funct3[2]=1 store is illegal.
    always_comb begin
        if (we) begin
            illegal = funct3[2] | (funct3[1:0] == 2'b11);
        end else begin
            illegal = (funct3 == 3'b011) | (funct3[2:1] == 2'b11);
        end
        misaligned = ((funct3[1:0] == 2'b01) & addr_lo[0]) |
                     ((funct3[1:0] == 2'b10) & (addr_lo != 2'b00));
    end

    always_comb begin
        err = ERR_NONE;
        if (illegal) begin
            err = ERR_ILLEGAL;
        end else if (misaligned) begin
            err = ERR_MISALIGN;
        end
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Memory-stage load/store controller: accepts one access at a time, runs the
// req/gnt + rvalid bus handshake and returns the raw word with a one-cycle pulse.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [3:0]  rsp_strobe,
    output logic [2:0]  rsp_funct3,
    output logic [1:0]  rsp_err,
    output logic        busy
);

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    lsu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             we_q, we_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [29:0]      waddr_q, waddr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       strobe_q, strobe_d;
    rsp_err_e         err_q, err_d;
    logic [31:0]      rdata_q, rdata_d;

    logic [3:0]       gen_strobe;
    logic [31:0]      gen_wdata;
    rsp_err_e         gen_err;

    lsu_strobe_gen u_strobe_gen (
        .we        (req_we),
        .funct3    (req_funct3),
        .addr_lo   (req_addr[1:0]),
        .wdata     (req_wdata),
        .strobe    (gen_strobe),
        .wdata_rep (gen_wdata),
        .err       (gen_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            funct3_q <= '0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            strobe_q <= '0;
            err_q    <= ERR_NONE;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            strobe_q <= strobe_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        funct3_d  = funct3_q;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        strobe_d  = strobe_q;
        err_d     = err_q;
        rdata_d   = rdata_q;
        req_ready = 1'b0;
        mem_req   = 1'b0;
        rsp_valid = 1'b0;

        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    waddr_d  = req_addr[31:2];
                    wdata_d  = gen_wdata;
                    strobe_d = gen_strobe;
                    err_d    = gen_err;
                    rdata_d  = '0;
                    state_d  = (gen_err != ERR_NONE) ? RESP : REQ;
                end
            end
            REQ: begin
                mem_req = 1'b1;
                if (mem_gnt) begin
                    if (we_q) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = '0;
                    end
                end
            end
            WAIT: begin
                // rvalid is checked first so a late-but-in-time response beats the timeout.
                if (mem_rvalid) begin
                    rdata_d = mem_rdata;
                    state_d = RESP;
                end else if (cnt_q == TMO_LAST) begin
                    err_d   = ERR_TIMEOUT;
                    rdata_d = '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Bus and response fields are forced to zero outside the states that own them.
    assign mem_we     = mem_req & we_q;
    assign mem_addr   = mem_req ? {waddr_q, 2'b00} : 32'h0;
    assign mem_be     = mem_req ? strobe_q : 4'b0000;
    assign mem_wdata  = (mem_req && we_q) ? wdata_q : 32'h0;

    assign rsp_rdata  = rsp_valid ? rdata_q : 32'h0;
    assign rsp_strobe = rsp_valid ? strobe_q : 4'b0000;
    assign rsp_funct3 = rsp_valid ? funct3_q : 3'b000;
    assign rsp_err    = rsp_valid ? err_q : ERR_NONE;

    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: a vector table of single accesses plus
// hand-written timeout, reset-abort and back-to-back sequences.
module tb_lsu_ctrl;
    import lsu_pkg::*;

    localparam int unsigned TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        mem_req;
    logic        mem_gnt = 1'b0;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [3:0]  rsp_strobe;
    logic [2:0]  rsp_funct3;
    logic [1:0]  rsp_err;
    logic        busy;

    lsu_ctrl #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .mem_req    (mem_req),
        .mem_gnt    (mem_gnt),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_strobe (rsp_strobe),
        .rsp_funct3 (rsp_funct3),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          gnt_dly;
        int          rv_dly;
        logic [31:0] rdata;
        logic [3:0]  strobe;
        logic [31:0] exp_wdata;
        logic [1:0]  err;
        logic [31:0] exp_rdata;
        int          lat;
    } vec_t;

    function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input int gnt_dly, input int rv_dly,
                                input logic [31:0] rdata, input logic [3:0] strobe,
                                input logic [31:0] exp_wdata, input logic [1:0] err,
                                input logic [31:0] exp_rdata, input int lat);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.gnt_dly = gnt_dly; v.rv_dly = rv_dly; v.rdata = rdata;
        v.strobe = strobe; v.exp_wdata = exp_wdata; v.err = err;
        v.exp_rdata = exp_rdata; v.lat = lat;
        return v;
    endfunction

    // Entered on a negedge with the DUT idle; returns on a negedge with the DUT idle.
    task automatic run_vec(input string tag, input vec_t v);
        bit is_err;
        is_err = (v.err != 2'b00);
        chk({tag, ".ready0"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = v.we;
        req_funct3 = v.f3;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = v.rdata;
        for (int cyc = 1; cyc <= v.lat; cyc++) begin
            @(negedge clk);
            req_valid  = 1'b0;
            mem_gnt    = !is_err && (cyc == 1 + v.gnt_dly);
            mem_rvalid = !is_err && !v.we && (cyc == 2 + v.gnt_dly + v.rv_dly);
            chk({tag, ".busy"}, 32'(busy), 32'd1);
            if (!is_err && cyc <= 1 + v.gnt_dly) begin
                chk({tag, ".mem_req"}, 32'(mem_req), 32'd1);
                chk({tag, ".mem_we"}, 32'(mem_we), 32'(v.we));
                chk({tag, ".mem_addr"}, mem_addr, {v.addr[31:2], 2'b00});
                chk({tag, ".mem_be"}, 32'(mem_be), 32'(v.strobe));
                if (v.we) chk({tag, ".mem_wdata"}, mem_wdata, v.exp_wdata);
            end else begin
                chk({tag, ".mem_req_lo"}, 32'(mem_req), 32'd0);
            end
            if (cyc == v.lat) begin
                chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
                chk({tag, ".rsp_rdata"}, rsp_rdata, v.exp_rdata);
                chk({tag, ".rsp_strobe"}, 32'(rsp_strobe), 32'(v.strobe));
                chk({tag, ".rsp_funct3"}, 32'(rsp_funct3), 32'(v.f3));
                chk({tag, ".rsp_err"}, 32'(rsp_err), 32'(v.err));
            end else begin
                chk({tag, ".rsp_quiet"}, 32'(rsp_valid), 32'd0);
            end
        end
        @(negedge clk);
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        chk({tag, ".idle_after"}, 32'(busy), 32'd0);
        chk({tag, ".rsp_drop"}, 32'(rsp_valid), 32'd0);
    endtask

    // LW with immediate gnt and no rvalid, optionally with rvalid on the last allowed cycle.
    task automatic run_timeout(input string tag, input bit rv_on_last);
        int lat;
        lat = 2 + TIMEOUT;
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = LW;
        req_addr   = 32'h0000_0100;
        mem_rdata  = 32'h0BAD_F00D;
        for (int cyc = 1; cyc <= lat; cyc++) begin
            @(negedge clk);
            req_valid  = 1'b0;
            mem_gnt    = (cyc == 1);
            mem_rvalid = rv_on_last && (cyc == lat - 1);
            if (cyc == lat) begin
                chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
                chk({tag, ".rsp_err"}, 32'(rsp_err), rv_on_last ? 32'd0 : 32'd3);
                chk({tag, ".rsp_rdata"}, rsp_rdata, rv_on_last ? 32'h0BAD_F00D : 32'h0);
            end else begin
                chk({tag, ".rsp_quiet"}, 32'(rsp_valid), 32'd0);
            end
        end
        @(negedge clk);
        mem_rvalid = 1'b1;
        chk({tag, ".idle"}, 32'(busy), 32'd0);
        chk({tag, ".ready"}, 32'(req_ready), 32'd1);
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk({tag, ".late_rv_ignored"}, 32'(rsp_valid), 32'd0);
        chk({tag, ".still_idle"}, 32'(busy), 32'd0);
    endtask

    vec_t vecs[13];

    initial begin
        vecs[0]  = mk(1'b0, LBU, 32'h0000_1003, 32'h0, 0, 0, 32'hAABB_CCDD, 4'b1000,
                      32'h0, 2'b00, 32'hAABB_CCDD, 3);
        vecs[1]  = mk(1'b1, SH, 32'h0000_2002, 32'h0000_BEEF, 2, 0, 32'h0, 4'b1100,
                      32'hBEEF_BEEF, 2'b00, 32'h0, 4);
        vecs[2]  = mk(1'b0, LW, 32'h0000_3001, 32'h0, 0, 0, 32'h0, 4'b1111,
                      32'h0, 2'b01, 32'h0, 1);
        vecs[3]  = mk(1'b1, 3'b011, 32'h0000_4000, 32'h1234_5678, 0, 0, 32'h0, 4'b0000,
                      32'h0, 2'b10, 32'h0, 1);
        vecs[4]  = mk(1'b1, SB, 32'h0000_5001, 32'h1234_5678, 0, 0, 32'h0, 4'b0010,
                      32'h7878_7878, 2'b00, 32'h0, 2);
        vecs[5]  = mk(1'b0, LH, 32'h0000_6002, 32'h0, 1, 2, 32'h1122_3344, 4'b1100,
                      32'h0, 2'b00, 32'h1122_3344, 6);
        vecs[6]  = mk(1'b0, LHU, 32'h0000_6001, 32'h0, 0, 0, 32'h0, 4'b0011,
                      32'h0, 2'b01, 32'h0, 1);
        vecs[7]  = mk(1'b0, LW, 32'h0000_7000, 32'h0, 0, 0, 32'hDEAD_BEEF, 4'b1111,
                      32'h0, 2'b00, 32'hDEAD_BEEF, 3);
        vecs[8]  = mk(1'b0, 3'b110, 32'h0000_8000, 32'h0, 0, 0, 32'h0, 4'b1111,
                      32'h0, 2'b10, 32'h0, 1);
        vecs[9]  = mk(1'b1, 3'b100, 32'h0000_8001, 32'h0, 0, 0, 32'h0, 4'b0010,
                      32'h0, 2'b10, 32'h0, 1);
        vecs[10] = mk(1'b0, 3'b111, 32'h0000_8003, 32'h0, 0, 0, 32'h0, 4'b0000,
                      32'h0, 2'b10, 32'h0, 1);
        vecs[11] = mk(1'b1, SW, 32'h0000_9004, 32'hCAFE_F00D, 0, 0, 32'h0, 4'b1111,
                      32'hCAFE_F00D, 2'b00, 32'h0, 2);
        vecs[12] = mk(1'b0, LB, 32'h0000_A002, 32'h0, 0, 0, 32'h5566_7788, 4'b0100,
                      32'h0, 2'b00, 32'h5566_7788, 3);

        // Reset state
        #2;
        chk("rst.req_ready", 32'(req_ready), 32'd1);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.mem_req", 32'(mem_req), 32'd0);
        chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst.mem_addr", mem_addr, 32'h0);
        chk("rst.rsp_rdata", rsp_rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        run_timeout("tmo", 1'b0);
        run_timeout("tmo_rv_last", 1'b1);

        // Reset while a load sits in WAIT
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = LW;
        req_addr   = 32'h0000_0200;
        @(negedge clk);
        req_valid = 1'b0;
        mem_gnt   = 1'b1;
        chk("abort.req_phase", 32'(mem_req), 32'd1);
        @(negedge clk);
        mem_gnt = 1'b0;
        chk("abort.in_wait", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort.busy", 32'(busy), 32'd0);
        chk("abort.ready", 32'(req_ready), 32'd1);
        chk("abort.mem_req", 32'(mem_req), 32'd0);
        @(negedge clk);
        rst_n      = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1357_9BDF;
        for (int cyc = 0; cyc < 3; cyc++) begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            chk("abort.no_rsp", 32'(rsp_valid), 32'd0);
            chk("abort.idle", 32'(busy), 32'd0);
        end
        run_vec("abort.next_lb", mk(1'b0, LB, 32'h0000_0C01, 32'h0, 0, 0, 32'hF0E1_D2C3,
                                    4'b0010, 32'h0, 2'b00, 32'hF0E1_D2C3, 3));

        // Two stores with req_valid held; gnt held high also exercises gnt-ignored outside REQ
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = SW;
        req_addr   = 32'h0000_B000;
        req_wdata  = 32'h1111_1111;
        mem_gnt    = 1'b1;
        chk("b2b.c0_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("b2b.c1_busy", 32'(busy), 32'd1);
        chk("b2b.c1_ready", 32'(req_ready), 32'd0);
        chk("b2b.c1_addr", mem_addr, 32'h0000_B000);
        chk("b2b.c1_wdata", mem_wdata, 32'h1111_1111);
        @(negedge clk);
        req_addr  = 32'h0000_C004;
        req_wdata = 32'h2222_2222;
        chk("b2b.c2_busy", 32'(busy), 32'd1);
        chk("b2b.c2_rsp", 32'(rsp_valid), 32'd1);
        chk("b2b.c2_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("b2b.c3_busy", 32'(busy), 32'd0);
        chk("b2b.c3_ready", 32'(req_ready), 32'd1);
        chk("b2b.c3_mem_req", 32'(mem_req), 32'd0);
        chk("b2b.c3_rsp", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        chk("b2b.c4_busy", 32'(busy), 32'd1);
        chk("b2b.c4_mem_req", 32'(mem_req), 32'd1);
        chk("b2b.c4_addr", mem_addr, 32'h0000_C004);
        chk("b2b.c4_wdata", mem_wdata, 32'h2222_2222);
        @(negedge clk);
        chk("b2b.c5_rsp", 32'(rsp_valid), 32'd1);
        chk("b2b.c5_busy", 32'(busy), 32'd1);
        @(negedge clk);
        mem_gnt = 1'b0;
        chk("b2b.c6_busy", 32'(busy), 32'd0);
        chk("b2b.c6_rsp", 32'(rsp_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Memory-stage load/store controller for the in-order pipeline.
- Accepts one load/store per request from the MEM stage and decodes the byte strobe from funct3 and addr[1:0].
- Sequences the data-memory bus through a req/gnt, rvalid handshake and returns the raw read word plus strobe/funct3 to the combinational load-extraction unit.
- Holds the pipeline busy while the access is outstanding and flags misaligned, illegal or timed-out accesses.

Parameters:
- TIMEOUT, 16, cycles allowed in WAIT for mem_rvalid before a bus error (>=2).
- CNT_W, 5, width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  MEM stage presents an access
- req_ready  out  1  controller can accept (IDLE only)
- req_we  in  1  1=store, 0=load
- req_funct3  in  3  RV32I load/store funct3
- req_addr  in  32  byte address
- req_wdata  in  32  store data, LSB-aligned
- mem_req  out  1  bus request
- mem_gnt  in  1  bus accepts the request this cycle
- mem_we  out  1  bus write enable
- mem_addr  out  32  word address {addr[31:2],2'b00}
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read word
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  captured raw word (0 for stores/errors)
- rsp_strobe  out  4  byte strobe of the completed access
- rsp_funct3  out  3  funct3 of the completed access
- rsp_err  out  2  00 ok, 01 misaligned, 10 illegal funct3, 11 bus timeout
- busy  out  1  state != IDLE; used as pipeline stall

Behaviour:
- Reset (async, rst_n=0): state=IDLE, counter=0. All outputs are 0 except req_ready=1. An outstanding mem_req drops immediately, mid-access included. No response is ever produced for an access killed by reset.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid: register we, funct3, addr, wdata, strobe and error.
  - Error found -> RESP, with no bus activity.
  - Otherwise -> REQ.
- Strobe decode:
  - funct3[1:0]=00 (byte): 4'b0001<<addr[1:0].
  - 01 (half): addr[1] ? 1100 : 0011.
  - 10 (word): 1111.
- Error decode, in priority order:
  - Illegal (10): load funct3 in {011,110,111}; store funct3 not in {000,001,010}.
  - Misaligned (01): half with addr[0]=1; word with addr[1:0]!=0.
- Write data: byte replicated 4x; half replicated 2x; word passed through.
- REQ:
  - mem_req=1 with mem_we/addr/be/wdata held stable until mem_gnt.
  - mem_gnt with store -> RESP.
  - mem_gnt with load -> WAIT, counter cleared.
  - No gnt -> stay in REQ; REQ has no timeout.
- WAIT:
  - mem_req=0.
  - mem_rvalid -> capture mem_rdata -> RESP.
  - Else counter++; when counter reaches TIMEOUT-1 without rvalid -> RESP with err=11 and rdata=0.
  - rvalid on the timeout cycle wins: data is captured and err=00.
- RESP:
  - rsp_valid=1 for exactly one cycle, with rsp_* held from the registers.
  - Next state is IDLE. req_ready=0 in RESP, so back-to-back accesses take a minimum 4-cycle spacing for a load.
- Latency, request accepted at cycle 0:
  - Load with gnt at 1 and rvalid at 2 -> rsp_valid at 3.
  - Store with gnt at 1 -> rsp_valid at 2.
  - Error -> rsp_valid at 1.
- Any mem_gnt or mem_rvalid outside REQ/WAIT is ignored.
- busy=1 in every state except IDLE.

Decomposition:
- Shared package (lsu_pkg):
  - funct3 constants: LB, LH, LW, LBU, LHU, SB, SH, SW.
  - rsp_err enum: ERR_NONE, ERR_MISALIGN, ERR_ILLEGAL, ERR_TIMEOUT.
  - FSM state enum.
- One combinational sub-module, lsu_strobe_gen: funct3, addr[1:0], we, wdata -> strobe, replicated wdata, err.

Test Plan:
- LBU at addr 0x1003, gnt at cycle 1, rvalid at cycle 2 with rdata=0xAABBCCDD -> mem_addr=0x1000, mem_be=1000, rsp_valid at cycle 3, rsp_rdata=0xAABBCCDD, rsp_strobe=1000, rsp_funct3=100, err=00.
- SH at addr 0x2002, wdata=0x0000BEEF, gnt delayed 3 cycles -> mem_req held 3 cycles with mem_be=1100, mem_wdata=0xBEEFBEEF, rsp_valid 1 cycle after gnt.
- LW at addr 0x3001 -> no mem_req ever, rsp_valid at cycle 1, err=01. Store with funct3=011 -> err=10.
- LW, gnt immediate, no rvalid, TIMEOUT=16 -> rsp_valid with err=11 and rdata=0; a later rvalid is ignored and state returns to IDLE.
- rst_n driven low during WAIT of a load -> mem_req=0, busy=0, req_ready=1 asynchronously; no rsp_valid after release; the next LB completes normally.
- Back-to-back req_valid held high for two SW accesses -> second accepted only on the IDLE cycle after RESP; busy is continuous except that IDLE cycle.
